// File: rtl/ysyx_040066_ifu_pkg.sv
// Shared definitions for the ysyx_040066 instruction-fetch unit.
// Holds the FSM state encoding, the NOP filler and the reset PC.
package ysyx_040066_defs;

   localparam int          XLEN_DEF     = 64;
   localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2
   } ifu_state_e;

   function automatic logic is_aligned(input logic [1:0] pc_lsb);
      return (pc_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/ysyx_040066_ifu.sv
// Instruction-fetch unit: owns the PC, issues one imem fetch at a time,
// and hands {pc, inst} to ID. Redirects from EX override everything.
module ysyx_040066_ifu
   import ysyx_040066_defs::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_inst,
   output logic            if_misalign
);

   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

   ifu_state_e      state_r, state_s;
   logic [XLEN-1:0] pc_r, pc_s;
   logic            drop_r, drop_s;
   logic            req_valid_r, req_valid_s;
   logic            if_valid_r, if_valid_s;
   logic [XLEN-1:0] if_pc_r, if_pc_s;
   logic [31:0]     if_inst_r, if_inst_s;
   logic            if_misalign_r, if_misalign_s;
   logic            req_fire_s;

   assign req_fire_s     = req_valid_r & imem_req_ready;
   assign imem_req_valid = req_valid_r;
   assign imem_req_addr  = pc_r;
   assign if_valid       = if_valid_r;
   assign if_pc          = if_pc_r;
   assign if_inst        = if_inst_r;
   assign if_misalign    = if_misalign_r;

   // Next-state, next-PC and output-slot logic; redirect wins in every state.
   always_comb begin
      state_s       = state_r;
      pc_s          = pc_r;
      drop_s        = drop_r;
      if_valid_s    = if_valid_r;
      if_pc_s       = if_pc_r;
      if_inst_s     = if_inst_r;
      if_misalign_s = if_misalign_r;
      case (state_r)
         S_REQ: begin
            if (redirect_valid) begin
               pc_s = redirect_pc;
               if (req_fire_s) begin
                  state_s = S_WAIT;
                  drop_s  = 1'b1;
               end else begin
                  state_s = S_REQ;
               end
            end else if (!is_aligned(pc_r[1:0])) begin
               state_s       = S_OUT;
               if_valid_s    = 1'b1;
               if_pc_s       = pc_r;
               if_inst_s     = NOP_INST;
               if_misalign_s = 1'b1;
            end else if (req_fire_s) begin
               state_s = S_WAIT;
            end else begin
               state_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_s = redirect_pc;
               if (imem_resp_valid) begin
                  state_s = S_REQ;
                  drop_s  = 1'b0;
               end else begin
                  state_s = S_WAIT;
                  drop_s  = 1'b1;
               end
            end else if (imem_resp_valid) begin
               // A response owed to a pre-redirect request is silently consumed.
               if (drop_r) begin
                  state_s = S_REQ;
                  drop_s  = 1'b0;
               end else begin
                  state_s       = S_OUT;
                  if_valid_s    = 1'b1;
                  if_pc_s       = pc_r;
                  if_inst_s     = imem_resp_data;
                  if_misalign_s = 1'b0;
               end
            end else begin
               state_s = S_WAIT;
            end
         end
         S_OUT: begin
            if (redirect_valid) begin
               pc_s       = redirect_pc;
               if_valid_s = 1'b0;
               state_s    = S_REQ;
            end else if (if_valid_r && if_ready) begin
               pc_s       = pc_r + PC_STEP;
               if_valid_s = 1'b0;
               state_s    = S_REQ;
            end else begin
               state_s = S_OUT;
            end
         end
         default: begin
            state_s    = S_REQ;
            drop_s     = 1'b0;
            if_valid_s = 1'b0;
         end
      endcase
      // Registered request strobe keeps imem_req_valid low throughout reset.
      req_valid_s = (state_s == S_REQ) && is_aligned(pc_s[1:0]);
   end

   // State, PC, drop flag and ID-facing output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_REQ;
         pc_r          <= RESET_PC;
         drop_r        <= 1'b0;
         req_valid_r   <= 1'b0;
         if_valid_r    <= 1'b0;
         if_pc_r       <= RESET_PC;
         if_inst_r     <= 32'h0000_0000;
         if_misalign_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         drop_r        <= drop_s;
         req_valid_r   <= req_valid_s;
         if_valid_r    <= if_valid_s;
         if_pc_r       <= if_pc_s;
         if_inst_r     <= if_inst_s;
         if_misalign_r <= if_misalign_s;
      end
   end

endmodule
